// File: rtl/conv2d_pkg.sv
// Shared types for the conv2D job scheduler: FSM state encoding and descriptor packing.
// Descriptor packing order, MSB to LSB: {ofm_base, ifm_base, wt_base, fm_dim}.
package conv2d_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_POP      = 3'd1,
      ST_LAUNCH   = 3'd2,
      ST_ARMED    = 3'd3,
      ST_RUN      = 3'd4,
      ST_COMPLETE = 3'd5
   } sched_state_t;

   localparam int unsigned DEF_AWIDTH = 32;
   localparam int unsigned DEF_DIM_W  = 32;

   // Packed descriptor width for a given address width and fm_dim width.
   function automatic int unsigned desc_width(input int unsigned awidth, input int unsigned dim_w);
      return 3 * awidth + dim_w;
   endfunction

endpackage

// File: rtl/conv2d_desc_fifo.sv
// Synchronous descriptor FIFO, 2^QLOG entries deep. Full/empty derive from a registered
// count, so push readiness never depends combinationally on the same-cycle pop.
module conv2d_desc_fifo #(
   parameter int unsigned W    = 128,
   parameter int unsigned QLOG = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int unsigned DEPTH = 1 << QLOG;
   localparam logic [QLOG:0] DEPTH_CNT = (QLOG+1)'(DEPTH);

   logic [W-1:0]    mem [DEPTH];
   logic [QLOG-1:0] wr_ptr_reg;
   logic [QLOG-1:0] rd_ptr_reg;
   logic [QLOG:0]   count_reg;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count_reg == DEPTH_CNT);
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/conv2d_job_scheduler.sv
// Queues conv2D job descriptors and runs them one at a time on a single compute engine.
// Optional macro CONV_SCHED_PERF_EN adds a per-job cycle counter reported on stat_cycles.
module conv2d_job_scheduler
   import conv2d_pkg::*;
#(
   parameter int unsigned AWIDTH = DEF_AWIDTH,
   parameter int unsigned DIM_W  = DEF_DIM_W,
   parameter int unsigned QLOG   = 2,
   parameter int unsigned ID_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [DIM_W-1:0]  job_fm_dim,
   input  logic [AWIDTH-1:0] job_wt_base,
   input  logic [AWIDTH-1:0] job_ifm_base,
   input  logic [AWIDTH-1:0] job_ofm_base,
   output logic [DIM_W-1:0]  cfg_fm_dim,
   output logic [AWIDTH-1:0] cfg_wt_base,
   output logic [AWIDTH-1:0] cfg_ifm_base,
   output logic [AWIDTH-1:0] cfg_ofm_base,
   output logic              compute_start,
   input  logic              compute_idle,
   input  logic              compute_done,
   output logic              stat_valid,
   input  logic              stat_ready,
   output logic [ID_W-1:0]   stat_id,
   output logic              stat_err,
   output logic [31:0]       stat_cycles,
   output logic              sched_busy
);

   localparam int unsigned DESC_W = desc_width(AWIDTH, DIM_W);

   logic [DESC_W-1:0] push_desc;
   logic [DESC_W-1:0] head_desc;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [DIM_W-1:0]  head_fm_dim;
   logic [AWIDTH-1:0] head_wt_base;
   logic [AWIDTH-1:0] head_ifm_base;
   logic [AWIDTH-1:0] head_ofm_base;

   sched_state_t      state_reg;
   sched_state_t      state_next;
   logic [DIM_W-1:0]  fm_dim_reg;
   logic [AWIDTH-1:0] wt_base_reg;
   logic [AWIDTH-1:0] ifm_base_reg;
   logic [AWIDTH-1:0] ofm_base_reg;
   logic              err_reg;
   logic [ID_W-1:0]   id_reg;

   assign push_desc     = {job_ofm_base, job_ifm_base, job_wt_base, job_fm_dim};
   assign head_fm_dim   = head_desc[DIM_W-1:0];
   assign head_wt_base  = head_desc[DIM_W +: AWIDTH];
   assign head_ifm_base = head_desc[DIM_W + AWIDTH +: AWIDTH];
   assign head_ofm_base = head_desc[DIM_W + 2*AWIDTH +: AWIDTH];

   conv2d_desc_fifo #(
      .W    (DESC_W),
      .QLOG (QLOG)
   ) u_desc_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (job_valid),
      .push_data (push_desc),
      .pop       (fifo_pop),
      .head      (head_desc),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign job_ready    = !fifo_full;
   assign sched_busy   = (state_reg != ST_IDLE) || !fifo_empty;
   assign stat_valid   = (state_reg == ST_COMPLETE);
   assign stat_id      = id_reg;
   assign stat_err     = err_reg;
   assign cfg_fm_dim   = fm_dim_reg;
   assign cfg_wt_base  = wt_base_reg;
   assign cfg_ifm_base = ifm_base_reg;
   assign cfg_ofm_base = ofm_base_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Done is only looked at in RUN; the ARMED gap lets the engine drop a stale done first.
   always_comb begin
      state_next    = state_reg;
      fifo_pop      = 1'b0;
      compute_start = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) state_next = ST_POP;
         end
         ST_POP: begin
            fifo_pop   = 1'b1;
            state_next = (head_fm_dim == '0) ? ST_COMPLETE : ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (compute_idle) begin
               compute_start = 1'b1;
               state_next    = ST_ARMED;
            end
         end
         ST_ARMED: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (compute_done && compute_idle) state_next = ST_COMPLETE;
         end
         ST_COMPLETE: begin
            if (stat_ready) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fm_dim_reg   <= '0;
         wt_base_reg  <= '0;
         ifm_base_reg <= '0;
         ofm_base_reg <= '0;
         err_reg      <= 1'b0;
         id_reg       <= '0;
      end else begin
         if (state_reg == ST_POP) begin
            fm_dim_reg   <= head_fm_dim;
            wt_base_reg  <= head_wt_base;
            ifm_base_reg <= head_ifm_base;
            ofm_base_reg <= head_ofm_base;
            err_reg      <= (head_fm_dim == '0);
         end
         if ((state_reg == ST_COMPLETE) && stat_ready) begin
            id_reg <= id_reg + 1'b1;
         end
      end
   end

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] cycles_reg;

   // Cleared in POP as well so a rejected job never reports the previous job's count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles_reg <= '0;
      end else if ((state_reg == ST_POP) || compute_start) begin
         cycles_reg <= '0;
      end else if (((state_reg == ST_ARMED) || (state_reg == ST_RUN)) && (cycles_reg != 32'hFFFF_FFFF)) begin
         cycles_reg <= cycles_reg + 32'd1;
      end
   end

   assign stat_cycles = cycles_reg;
`else
   assign stat_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv2d_job_scheduler.sv
// Directed bench for conv2d_job_scheduler with a behavioural engine model and a
// scoreboard of expected status records pushed at descriptor acceptance.
module tb_conv2d_job_scheduler;

   localparam int ENG_LAT = 20;
`ifdef CONV_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid;
   logic        job_ready;
   logic [31:0] job_fm_dim;
   logic [31:0] job_wt_base;
   logic [31:0] job_ifm_base;
   logic [31:0] job_ofm_base;
   logic [31:0] cfg_fm_dim;
   logic [31:0] cfg_wt_base;
   logic [31:0] cfg_ifm_base;
   logic [31:0] cfg_ofm_base;
   logic        compute_start;
   logic        compute_idle;
   logic        compute_done;
   logic        stat_valid;
   logic        stat_ready;
   logic [7:0]  stat_id;
   logic        stat_err;
   logic [31:0] stat_cycles;
   logic        sched_busy;

   conv2d_job_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_fm_dim    (job_fm_dim),
      .job_wt_base   (job_wt_base),
      .job_ifm_base  (job_ifm_base),
      .job_ofm_base  (job_ofm_base),
      .cfg_fm_dim    (cfg_fm_dim),
      .cfg_wt_base   (cfg_wt_base),
      .cfg_ifm_base  (cfg_ifm_base),
      .cfg_ofm_base  (cfg_ofm_base),
      .compute_start (compute_start),
      .compute_idle  (compute_idle),
      .compute_done  (compute_done),
      .stat_valid    (stat_valid),
      .stat_ready    (stat_ready),
      .stat_id       (stat_id),
      .stat_err      (stat_err),
      .stat_cycles   (stat_cycles),
      .sched_busy    (sched_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  id;
      logic        err;
      logic [31:0] cycles;
      logic [31:0] dim;
      logic [31:0] wt;
      logic [31:0] ofm;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_id = 0;
   int   job_seq = 0;
   int   start_cnt = 0;
   int   cyc = 0;
   int   last_start_cyc = 0;
   int   last_lat = 0;
   bit   running = 1'b0;
   bit   prev_start = 1'b0;
   bit   prev_valid = 1'b0;
   logic [31:0] run_dim = '0;

   // Engine model
   logic eng_done, eng_idle, eng_hold, stale_mode, clr_pend;
   int   eng_cnt;

   assign compute_done = eng_done;
   assign compute_idle = eng_idle && !eng_hold;

   always @(posedge clk) cyc <= cyc + 1;

   // Done rises ENG_LAT+1 cycles after the start cycle; stale mode keeps done/idle high one extra cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_done <= 1'b0;
         eng_idle <= 1'b1;
         eng_cnt  <= 0;
         clr_pend <= 1'b0;
      end else if (compute_start) begin
         eng_cnt        <= ENG_LAT;
         last_start_cyc <= cyc;
         if (stale_mode) begin
            clr_pend <= 1'b1;
         end else begin
            eng_done <= 1'b0;
            eng_idle <= 1'b0;
         end
      end else begin
         if (clr_pend) begin
            clr_pend <= 1'b0;
            eng_done <= 1'b0;
            eng_idle <= 1'b0;
         end
         if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
               eng_done <= 1'b1;
               eng_idle <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: start-pulse sanity, cfg hold while running, scoreboard compare on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (compute_start) begin
            chk("start_when_idle", compute_idle, 1);
            chk("start_one_cycle", prev_start, 0);
            start_cnt++;
            run_dim = cfg_fm_dim;
            running = 1'b1;
         end else if (running) begin
            chk("cfg_hold", cfg_fm_dim, run_dim);
         end
         if (stat_valid && !prev_valid) last_lat = cyc - last_start_cyc;
         if (stat_valid && stat_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", sb.size(), 1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("stat_id", stat_id, e.id);
               chk("stat_err", stat_err, e.err);
               chk("stat_cycles", stat_cycles, e.cycles);
               chk("cfg_fm_dim", cfg_fm_dim, e.dim);
               chk("cfg_wt_base", cfg_wt_base, e.wt);
               chk("cfg_ofm_base", cfg_ofm_base, e.ofm);
               $display("stat id=%0d err=%0d cycles=%0d dim=%0d", stat_id, stat_err, stat_cycles, cfg_fm_dim);
            end
            running = 1'b0;
         end
         prev_start = compute_start;
         prev_valid = stat_valid;
      end else begin
         running    = 1'b0;
         prev_start = 1'b0;
         prev_valid = 1'b0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic push_job(input logic [31:0] dim, input int budget);
      int   waited = 0;
      exp_t e;
      job_valid    = 1'b1;
      job_fm_dim   = dim;
      job_wt_base  = 32'h1000_0000 + 32'(job_seq * 16);
      job_ifm_base = 32'h2000_0000 + 32'(job_seq);
      job_ofm_base = 32'h3000_0000 ^ {dim[15:0], 16'h0};
      @(negedge clk);
      while (!job_ready && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (!job_ready) begin
         chk("push_timeout", job_ready, 1);
         @(posedge clk); #1;
         job_valid = 1'b0;
         return;
      end
      e.id     = 8'(exp_id);
      e.err    = (dim == 0);
      e.cycles = (dim == 0 || !PERF) ? 32'd0 : 32'(ENG_LAT + 1);
      e.dim    = dim;
      e.wt     = job_wt_base;
      e.ofm    = job_ofm_base;
      sb.push_back(e);
      $display("push id=%0d dim=%0d", exp_id, dim);
      exp_id++;
      job_seq++;
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int waited = 0;
      @(negedge clk);
      while ((sb.size() != 0 || sched_busy) && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      chk("drain_done", sched_busy || (sb.size() != 0), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      exp_id = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   int          base;
   int          waited;
   logic [7:0]  hold_id;
   logic [31:0] hold_cycles;
   logic [31:0] hold_dim;

   initial begin
      rst_n        = 1'b0;
      job_valid    = 1'b0;
      job_fm_dim   = '0;
      job_wt_base  = '0;
      job_ifm_base = '0;
      job_ofm_base = '0;
      stat_ready   = 1'b1;
      eng_hold     = 1'b0;
      stale_mode   = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_job_ready", job_ready, 1);
      chk("rst_stat_valid", stat_valid, 0);
      chk("rst_start", compute_start, 0);
      chk("rst_cfg_dim", cfg_fm_dim, 0);
      chk("rst_cfg_ifm", cfg_ifm_base, 0);
      chk("rst_stat_id", stat_id, 0);
      chk("rst_stat_cycles", stat_cycles, 0);
      chk("rst_busy", sched_busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single job, fm_dim=4
      base = start_cnt;
      push_job(32'd4, 10);
      drain(500);
      chk("t1_starts", start_cnt - base, 1);
      chk("t1_latency", last_lat, ENG_LAT + 2);

      // FIFO fill: first job stalled in LAUNCH, four more fill the FIFO, one more waits
      do_reset();
      base = start_cnt;
      eng_hold = 1'b1;
      push_job(32'd11, 10);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push_job(32'(20 + i), 10);
      @(negedge clk);
      chk("t2_ready_low", job_ready, 0);
      repeat (5) @(negedge clk);
      chk("t2_ready_still_low", job_ready, 0);
      chk("t2_no_start_held", start_cnt - base, 0);
      @(posedge clk); #1;
      eng_hold = 1'b0;
      push_job(32'd24, 300);
      drain(1000);
      chk("t2_starts", start_cnt - base, 6);

      // Rejected fm_dim=0 job between two valid ones
      do_reset();
      base = start_cnt;
      push_job(32'd7, 10);
      push_job(32'd0, 10);
      push_job(32'd9, 10);
      drain(1000);
      chk("t3_starts", start_cnt - base, 2);

      // Status back-pressure for 50 cycles
      stat_ready = 1'b0;
      base = start_cnt;
      push_job(32'd5, 10);
      push_job(32'd6, 10);
      waited = 0;
      @(negedge clk);
      while (!stat_valid && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("t4_stat_valid_seen", stat_valid, 1);
      hold_id     = stat_id;
      hold_cycles = stat_cycles;
      hold_dim    = cfg_fm_dim;
      repeat (50) begin
         @(negedge clk);
         chk("t4_hold_valid", stat_valid, 1);
         chk("t4_hold_id", stat_id, hold_id);
      end
      chk("t4_hold_cycles", stat_cycles, hold_cycles);
      chk("t4_hold_dim", cfg_fm_dim, hold_dim);
      chk("t4_one_start_only", start_cnt - base, 1);
      @(posedge clk); #1;
      stat_ready = 1'b1;
      drain(500);
      chk("t4_starts", start_cnt - base, 2);

      // Stale done left high from the previous job lingers into ARMED
      stale_mode = 1'b1;
      base = start_cnt;
      push_job(32'd8, 10);
      drain(500);
      chk("t5_latency", last_lat, ENG_LAT + 2);
      chk("t5_starts", start_cnt - base, 1);
      stale_mode = 1'b0;

      // Reset mid-RUN with two jobs still queued
      base = start_cnt;
      push_job(32'd3, 10);
      push_job(32'd4, 10);
      push_job(32'd5, 10);
      waited = 0;
      @(negedge clk);
      while (start_cnt == base && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      repeat (5) @(negedge clk);
      chk("t6_pre_busy", sched_busy, 1);
      chk("t6_pre_cfg", cfg_fm_dim, 3);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cfg", cfg_fm_dim, 0);
      chk("t6_rst_wt", cfg_wt_base, 0);
      chk("t6_rst_start", compute_start, 0);
      chk("t6_rst_valid", stat_valid, 0);
      chk("t6_rst_busy", sched_busy, 0);
      chk("t6_rst_ready", job_ready, 1);
      sb.delete();
      exp_id = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      base = start_cnt;
      push_job(32'd13, 10);
      drain(500);
      chk("t6_restart_starts", start_cnt - base, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
